// File: rtl/matmul_result_serializer_if.sv
// Result-serializer bus: done/result capture side plus byte-wide valid/ready stream and overrun status.
interface matmul_result_serializer_if #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 16
);
  logic                       done_in;
  logic [N_ELEM*ELEM_W-1:0]   c_flat;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       busy;
  logic                       overrun;
  logic                       ovr_clr;

  // Serializer side
  modport slave (
    input  done_in, c_flat, out_ready, ovr_clr,
    output out_data, out_valid, out_last, busy, overrun
  );

  // Multiplier / sink side
  modport master (
    output done_in, c_flat, out_ready, ovr_clr,
    input  out_data, out_valid, out_last, busy, overrun
  );
endinterface

// File: rtl/matmul_result_serializer.sv
// Shadows the 144-bit result on done_in and streams it out as 18 bytes, element 0 low byte first.
// First byte 1 cycle after done_in; holds byte under out_ready low; done_in while busy is dropped and flagged.
module matmul_result_serializer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matmul_result_serializer_if.slave bus
);
  localparam int BYTES_PER_ELEM = ELEM_W / 8;
  localparam int N_BYTES        = N_ELEM * BYTES_PER_ELEM;
  localparam int SHADOW_W       = N_ELEM * ELEM_W;
  localparam int IDX_W          = 5;
  localparam int OFF_W          = $clog2(SHADOW_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                ovr_q, ovr_d;

  logic                valid_w;
  logic                xfer_w;
  logic                final_xfer_w;
  logic                ovr_set_w;
  logic [OFF_W-1:0]    byte_off_w;

  assign valid_w      = (state_q == SEND);
  assign xfer_w       = valid_w && bus.out_ready;
  assign final_xfer_w = xfer_w && (idx_q == LAST_IDX);
  assign byte_off_w   = OFF_W'(idx_q) << 3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ovr_set_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.done_in) begin
          shadow_d = bus.c_flat;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (final_xfer_w) begin
          idx_d = '0;
          // A capture landing on the final transfer chains the next frame with no bubble.
          if (bus.done_in) begin
            shadow_d = bus.c_flat;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer_w) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (bus.done_in && !final_xfer_w) begin
          ovr_set_w = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    if (ovr_set_w) begin
      ovr_d = 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign bus.out_valid = valid_w;
  assign bus.busy      = valid_w;
  assign bus.out_last  = valid_w && (idx_q == LAST_IDX);
  assign bus.out_data  = shadow_q[byte_off_w +: 8];
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_matmul_result_serializer.sv
// Scoreboard bench for matmul_result_serializer: expected bytes queued at capture, checked on each transfer.
module tb_matmul_result_serializer;
  logic clk;
  logic rst_n;

  matmul_result_serializer_if #(.N_ELEM(9), .ELEM_W(16)) bus ();

  matmul_result_serializer #(.N_ELEM(9), .ELEM_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;
  int   last_cnt;
  logic stall_prev;
  logic [7:0] data_prev;
  logic last_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transfers observed mid-cycle; the edge that follows completes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_vld", {31'b0, bus.out_valid}, 32'd1);
        check("hold_dat", {24'b0, bus.out_data}, {24'b0, data_prev});
        check("hold_last", {31'b0, bus.out_last}, {31'b0, last_prev});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_byte", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("byte", {24'b0, bus.out_data}, {24'b0, e.dat});
          check("last", {31'b0, bus.out_last}, {31'b0, e.last});
        end
        if (bus.out_last) last_cnt++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
    end
  end

  task automatic push_frame(input logic [143:0] v);
    exp_t e;
    for (int i = 0; i < 18; i++) begin
      e.dat  = v[i*8 +: 8];
      e.last = (i == 17);
      q.push_back(e);
    end
  endtask

  // Drives done_in for one cycle; push=0 for a pulse expected to be dropped.
  task automatic pulse_done(input logic [143:0] v, input logic push, input logic clr);
    @(posedge clk); #1;
    bus.c_flat  = v;
    bus.done_in = 1'b1;
    bus.ovr_clr = clr;
    if (push) push_frame(v);
    @(posedge clk); #1;
    bus.done_in = 1'b0;
    bus.ovr_clr = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int budget, output int gaps);
    int i;
    gaps = 0;
    for (i = 0; i < budget; i++) begin
      if (q.size() == 0 && !bus.busy) break;
      if (!bus.out_valid) gaps++;
      @(posedge clk); #1;
      bus.out_ready = pat[i % 4];
    end
    check("drain_timeout", (i < budget) ? 32'd1 : 32'd0, 32'd1);
    bus.out_ready = 1'b1;
  endtask

  function automatic logic [143:0] fill(input logic [15:0] e);
    logic [143:0] v;
    for (int k = 0; k < 9; k++) v[k*16 +: 16] = e;
    return v;
  endfunction

  logic [143:0] v;
  int gaps;
  int lc0;

  initial begin
    n_tests = 0; n_fail = 0; last_cnt = 0;
    stall_prev = 1'b0; data_prev = '0; last_prev = 1'b0;
    rst_n = 1'b0;
    bus.done_in = 1'b0; bus.c_flat = '0; bus.out_ready = 1'b1; bus.ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_last", {31'b0, bus.out_last}, 32'd0);
    check("rst_ovr", {31'b0, bus.overrun}, 32'd0);
    check("rst_data", {24'b0, bus.out_data}, 32'd0);
    rst_n = 1'b1;

    // Basic frame with explicit one-cycle latency check
    for (int k = 0; k < 9; k++) v[k*16 +: 16] = 16'(k + 1);
    @(posedge clk); #1;
    bus.c_flat = v; bus.done_in = 1'b1; push_frame(v);
    @(negedge clk);
    check("pre_cap_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    bus.done_in = 1'b0;
    check("lat_valid", {31'b0, bus.out_valid}, 32'd1);
    check("lat_busy", {31'b0, bus.busy}, 32'd1);
    lc0 = last_cnt;
    drain(4'b1111, 100, gaps);
    check("basic_gaps", gaps, 0);
    check("basic_lastcnt", last_cnt - lc0, 1);
    check("basic_busy_end", {31'b0, bus.busy}, 32'd0);

    // Backpressure, ready pattern 1,0,0,1
    for (int k = 0; k < 9; k++) v[k*16 +: 16] = 16'($urandom);
    v[15:0] = 16'hBEEF;
    pulse_done(v, 1'b1, 1'b0);
    drain(4'b1001, 200, gaps);
    check("bp_q_empty", q.size(), 0);

    // Input change right after capture must not leak into the frame
    for (int k = 0; k < 9; k++) v[k*16 +: 16] = 16'(16'h0A00 + k);
    pulse_done(v, 1'b1, 1'b0);
    bus.c_flat = '1;
    drain(4'b1111, 100, gaps);

    // Overrun at byte 5, frame continues with original data
    v = fill(16'h5A3C);
    pulse_done(v, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    pulse_done(fill(16'hDEAD), 1'b0, 1'b0);
    drain(4'b1111, 100, gaps);
    check("ovr_set", {31'b0, bus.overrun}, 32'd1);
    @(posedge clk); #1;
    bus.ovr_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr = 1'b0;
    check("ovr_clr", {31'b0, bus.overrun}, 32'd0);
    pulse_done(fill(16'h0F0F), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    pulse_done(fill(16'hCAFE), 1'b0, 1'b1);
    check("ovr_set_wins", {31'b0, bus.overrun}, 32'd1);
    drain(4'b1111, 100, gaps);
    @(posedge clk); #1;
    bus.ovr_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr = 1'b0;

    // Back-to-back frames on the final-transfer cycle
    lc0 = last_cnt;
    pulse_done(fill(16'h1111), 1'b1, 1'b0);
    gaps = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_last) break;
      if (!bus.out_valid) gaps++;
      @(posedge clk); #1;
    end
    check("b2b_saw_last", {31'b0, bus.out_last}, 32'd1);
    bus.c_flat = fill(16'h2222); bus.done_in = 1'b1; push_frame(fill(16'h2222));
    @(posedge clk); #1;
    bus.done_in = 1'b0;
    check("b2b_valid_cont", {31'b0, bus.out_valid}, 32'd1);
    check("b2b_gaps_a", gaps, 0);
    drain(4'b1111, 100, gaps);
    check("b2b_gaps_b", gaps, 0);
    check("b2b_ovr", {31'b0, bus.overrun}, 32'd0);
    check("b2b_lastcnt", last_cnt - lc0, 2);

    // Asynchronous reset mid-frame, then a fresh frame
    pulse_done(fill(16'h7777), 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_valid", {31'b0, bus.out_valid}, 32'd0);
    check("amid_busy", {31'b0, bus.busy}, 32'd0);
    check("amid_last", {31'b0, bus.out_last}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) v[k*16 +: 16] = 16'(16'h3100 + k);
    pulse_done(v, 1'b1, 1'b0);
    drain(4'b1111, 100, gaps);
    check("post_rst_q", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matmul_result_serializer.md
Name: matmul_result_serializer

Overview:
Drains the 3x3 matrix multiplier's 144-bit result bus (nine 16-bit elements) onto a byte-wide valid/ready output stream for the chip's 8-bit output pins. It captures the result on the multiplier's one-cycle done pulse into a shadow register, then emits 18 bytes in order. It flags results that arrive while a previous result is still being sent.

Parameters:
N_ELEM, 9, number of result elements per frame
ELEM_W, 16, bits per element; must be a multiple of 8
BYTES_PER_ELEM, ELEM_W/8 (derived, 2), bytes emitted per element

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
done_in  input  1  one-cycle pulse from the multiplier: c_flat is valid this cycle
c_flat  input  N_ELEM*ELEM_W (144)  packed result; element k at bits [16k+15:16k]
out_data  output  8  current output byte
out_valid  output  1  out_data holds a byte not yet accepted
out_ready  input  1  sink accepts the byte this cycle
out_last  output  1  high with the final byte of a frame
busy  output  1  frame captured and not fully sent
overrun  output  1  sticky: a done_in pulse was dropped
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; byte index 0; shadow register 0; out_valid 0; out_last 0; busy 0; overrun 0; out_data 0.
- Capture: in IDLE, done_in high -> shadow <= c_flat, index <= 0, state SEND.
  - out_valid and busy rise on the next cycle, so latency is 1 cycle from done_in to the first byte presented.
  - c_flat is sampled only on the capture edge. Later changes on c_flat do not affect the frame.
- Byte order: element 0 first through element 8. Within each element, low byte first.
  - Byte i = shadow[8i+7:8i], for i = 0..17.
- Handshake: a transfer occurs on a cycle with out_valid && out_ready.
  - out_data and out_last stay stable while out_valid is high and out_ready is low.
  - out_valid never drops without a transfer, except on reset.
  - On each transfer the index increments. The next byte appears the following cycle, so one byte per cycle is possible with out_ready held high.
- out_last is high exactly when index == 17 and out_valid is high.
- End of frame: on the transfer at index 17 -> state IDLE, out_valid 0, busy 0, unless a back-to-back capture occurs (below).
- Back-to-back capture: done_in high in the same cycle as the final transfer.
  - The new result is captured, index returns to 0, and state stays SEND.
  - out_valid stays high continuously and byte 0 of the new frame is presented next cycle.
  - overrun is not set.
- Overrun: done_in high in SEND at any time other than the final-transfer cycle.
  - The pulse is ignored and the shadow register and index are unchanged.
  - overrun <= 1 and holds until ovr_clr.
- ovr_clr and a new overrun event in the same cycle: set wins, so overrun stays 1.
- Reset mid-frame: output returns to its reset values immediately (asynchronously). The partial frame is discarded with no resume.
- FSM: two states, IDLE and SEND. Byte index is a 5-bit counter, 0..17, with no wrap beyond 17.

Test Plan:
- Basic frame: c_flat elements 0x0001..0x0009, pulse done_in, out_ready=1 -> out_valid rises 1 cycle later.
  - Bytes 01 00 02 00 ... 09 00 are sent over 18 consecutive cycles.
  - out_last is high only on the 18th byte, then busy=0.
- Backpressure: element0=0xBEEF, out_ready toggling 1,0,0,1 -> out_data holds 0xEF through the stalled cycles; next byte 0xBE appears only after the transfer.
  - No byte is lost or duplicated across the full frame.
- Input stability: change c_flat to all 0xFF the cycle after done_in -> the emitted frame still matches the captured values.
- Overrun: pulse done_in at byte 5 of a frame -> the frame completes with the original data and overrun=1.
  - ovr_clr=1 for one cycle -> overrun=0.
  - ovr_clr coincident with a new overrun pulse -> overrun remains 1.
- Back-to-back: frame A = 0x1111s, second done_in with frame B = 0x2222s on the final-transfer cycle -> 36 contiguous bytes (18×0x11 then 18×0x22) with out_valid never low.
  - overrun stays 0; out_last pulses twice.
- Reset mid-frame: assert rst_n low at byte 7 -> out_valid, busy and out_last go to 0 immediately.
  - After release, a new done_in starts a fresh frame from byte 0.
